// File: rtl/alu_ctrl.sv
// Two-requester round-robin front end for the serial bit-stream ALU: frames requests
// onto alu_din and collects tagged responses from alu_dout. Define ALU_CHECK_EN to build the flag checker.
module alu_ctrl #(
    parameter int unsigned N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [1:0]     req0_op,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    input  logic [1:0]     req1_op,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           req0_ready,
    output logic           req1_ready,
    output logic           alu_rst,
    output logic           alu_din,
    input  logic           alu_dout,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    output logic           rsp_parity,
    output logic           rsp_zero,
    output logic           rsp_err
);
    localparam int unsigned F  = 2 + 2 * N;
    localparam int unsigned RW = 2 * N;
    localparam int unsigned SW = $clog2(F);
    localparam logic [SW-1:0] LAST = SW'(F - 1);

    typedef enum logic {ST_START, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q;
    logic            rr_q;
    logic [F-1:0]    tx_sr;
    logic [F-2:0]    rx_sr;
    logic            tag0_v, tag0_id, tag1_v, tag1_id;
    logic            frame_start;
    logic            take0, take1;
    logic [F-1:0]    load_vec;
    logic [RW-1:0]   res_full;

    // Frame boundary, round-robin grant and next frame payload
    always_comb begin
        state_d     = ST_RUN;
        frame_start = (state_q == ST_START) || (slot_q == LAST);
        take0       = 1'b0;
        take1       = 1'b0;
        load_vec    = {2'b10, {RW{1'b0}}};
        if (frame_start && rst_n) begin
            if (req0_valid && (!rr_q || !req1_valid)) begin
                take0    = 1'b1;
                load_vec = {req0_op, req0_a, req0_b};
            end else if (req1_valid) begin
                take1    = 1'b1;
                load_vec = {req1_op, req1_a, req1_b};
            end
        end
    end

    assign req0_ready = take0;
    assign req1_ready = take1;
    assign res_full   = {rx_sr[RW-2:0], alu_dout};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer, return-path capture and two-frame tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            rr_q       <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            alu_din    <= 1'b0;
            alu_rst    <= 1'b1;
            tag0_v     <= 1'b0;
            tag0_id    <= 1'b0;
            tag1_v     <= 1'b0;
            tag1_id    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_parity <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            alu_rst   <= 1'b0;
            rsp_valid <= 1'b0;
            rx_sr     <= {rx_sr[F-3:0], alu_dout};
            if (frame_start) begin
                slot_q  <= '0;
                alu_din <= load_vec[F-1];
                tx_sr   <= load_vec << 1;
                tag0_v  <= take0 | take1;
                tag0_id <= take1;
                if (take0 | take1) begin
                    rr_q <= take0;
                end
                // The first frame after reset has no returning results yet
                if (state_q == ST_RUN) begin
                    tag1_v     <= tag0_v;
                    tag1_id    <= tag0_id;
                    rsp_valid  <= tag1_v;
                    rsp_id     <= tag1_id;
                    rsp_parity <= rx_sr[RW];
                    rsp_zero   <= rx_sr[RW-1];
                    rsp_result <= res_full;
                end
            end else begin
                slot_q  <= slot_q + SW'(1);
                alu_din <= tx_sr[F-1];
                tx_sr   <= tx_sr << 1;
            end
        end
    end

`ifdef ALU_CHECK_EN
    // Cross-check the reported flags against the captured result bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= 1'b0;
            if (frame_start && (state_q == ST_RUN)) begin
                rsp_err <= tag1_v && (((^res_full) != rx_sr[RW]) ||
                                      ((res_full == '0) != rx_sr[RW-1]));
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: serial ALU model, per-cycle scoreboard and literal expectations.
module tb_alu_ctrl;
    localparam int F = 6;
`ifdef ALU_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic [1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready;
    logic       alu_rst, alu_din;
    logic       alu_dout = 1'b0;
    logic       rsp_valid, rsp_id, rsp_parity, rsp_zero, rsp_err;
    logic [3:0] rsp_result;

    alu_ctrl #(.N(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_rst(alu_rst), .alu_din(alu_din), .alu_dout(alu_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_parity(rsp_parity), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       v;
        logic       id;
        logic [3:0] res;
        logic       par;
        logic       zero;
        logic       err;
    } exp_t;

    typedef struct {
        int         start;
        logic [5:0] pat;
    } dlit_t;

    exp_t  q[$];
    exp_t  lit[16];
    int    n_lit = 0;
    dlit_t dl[8];
    int    n_dl = 0;
    logic  inject = 1'b0;
    int    flip_cyc = -1;
    int    n_assert = 0;
    int    n_fail = 0;

    function automatic logic [3:0] calc(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        int r;
        case (op)
            2'b10:   r = int'(a) + int'(b);
            2'b01:   r = int'(a) - int'(b);
            2'b11:   r = int'(a) * int'(b);
            default: r = (b == 2'd0) ? 0 : int'(a) / int'(b);
        endcase
        return 4'(r);
    endfunction

    // Serial ALU: samples on negedge, returns frame k's flags and result during frame k+1
    initial begin
        int         acnt;
        logic [5:0] ain, aout;
        logic [3:0] r;
        logic       b;
        acnt = 0; ain = '0; aout = '0;
        forever begin
            @(negedge clk);
            if (alu_rst) begin
                acnt = 0; ain = '0; aout = '0; alu_dout = 1'b0;
            end else begin
                if (acnt == 0) begin
                    r    = calc(ain[5:4], ain[3:2], ain[1:0]);
                    aout = {^r, r == 4'd0, r};
                end
                b = aout[F-1-acnt];
                if (cyc == flip_cyc && acnt == 1) b = ~b;
                alu_dout = b;
                ain[F-1-acnt] = alu_din;
                acnt = (acnt + 1) % F;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: model of framing, arbitration and response timing
    initial begin
        int         start_c;
        logic       ptr, grant, any, w, exp_v;
        logic [5:0] cur_vec;
        logic [1:0] op, a, b;
        exp_t       e;
        start_c = 0; ptr = 1'b0; cur_vec = 6'b100000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                start_c = cyc + 2;
                ptr = 1'b0;
                chk("rst_alu_rst", 32'(alu_rst), 32'd1);
                chk("rst_outputs", 32'({alu_din, rsp_valid, rsp_id, rsp_result, rsp_parity,
                                        rsp_zero, rsp_err, req0_ready, req1_ready}), 32'd0);
            end else begin
                chk("alu_rst", 32'(alu_rst), 32'(cyc < start_c));
                if (cyc >= start_c)
                    chk("alu_din", 32'(alu_din), 32'(cur_vec[F-1-((cyc - start_c) % F)]));
                grant = (cyc + 1 >= start_c) && (((cyc + 1 - start_c) % F) == 0);
                any   = req0_valid || req1_valid;
                w     = (req0_valid && (!ptr || !req1_valid)) ? 1'b0 : 1'b1;
                chk("req0_ready", 32'(req0_ready), 32'(grant && any && !w));
                chk("req1_ready", 32'(req1_ready), 32'(grant && any && w));
                exp_v = (q.size() > 0) && (q[0].due == cyc);
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (exp_v) begin
                    e = q.pop_front();
                    chk("rsp_fields", 32'({rsp_id, rsp_result, rsp_parity, rsp_zero, rsp_err}),
                        32'({e.id, e.res, e.par, e.zero, e.err}));
                end
                for (int i = 0; i < n_lit; i++) begin
                    if (lit[i].due == cyc) begin
                        chk("lit_rsp_valid", 32'(rsp_valid), 32'(lit[i].v));
                        if (lit[i].v) begin
                            chk("lit_rsp_id", 32'(rsp_id), 32'(lit[i].id));
                            chk("lit_rsp_result", 32'(rsp_result), 32'(lit[i].res));
                            chk("lit_rsp_flags", 32'({rsp_parity, rsp_zero, rsp_err}),
                                32'({lit[i].par, lit[i].zero, lit[i].err}));
                        end
                    end
                end
                for (int i = 0; i < n_dl; i++) begin
                    if (cyc >= dl[i].start && cyc < dl[i].start + F)
                        chk("lit_alu_din", 32'(alu_din), 32'(dl[i].pat[F-1-(cyc - dl[i].start)]));
                end
                if (grant) begin
                    if (any) begin
                        op = w ? req1_op : req0_op;
                        a  = w ? req1_a : req0_a;
                        b  = w ? req1_b : req0_b;
                        e.due  = cyc + 13;
                        e.v    = 1'b1;
                        e.id   = w;
                        e.res  = calc(op, a, b);
                        e.par  = ^e.res;
                        e.zero = (e.res == 4'd0);
                        e.err  = 1'b0;
                        if (inject) begin
                            e.zero   = ~e.zero;
                            e.err    = CHK;
                            flip_cyc = cyc + 8;
                        end
                        q.push_back(e);
                        cur_vec = {op, a, b};
                        ptr = ~w;
                    end else begin
                        cur_vec = 6'b100000;
                    end
                end
            end
        end
    end

    task automatic add_lit(input int due, input logic v, input logic id, input logic [3:0] res,
                           input logic par, input logic zero, input logic err);
        lit[n_lit] = '{due, v, id, res, par, zero, err};
        n_lit++;
    endtask

    task automatic add_din(input int start, input logic [5:0] pat);
        dl[n_dl] = '{start, pat};
        n_dl++;
    endtask

    task automatic set_req(input int port, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        if (port == 0) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input int port, output int t);
        bit got;
        got = 0;
        t = 0;
        for (int i = 0; i < 3 * F && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) begin
                got = 1;
                t = cyc + 1;
            end
        end
        if (!got) begin
            $display("FAIL accept_timeout: port %0d got no ready, required ready within %0d cycles", port, 3 * F);
            $fatal(1, "accept timeout");
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Directed scenarios
    initial begin
        int t, ta, tb;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        set_req(0, 2'b11, 2'd1, 2'd1);
        wait_accept(0, t);
        add_din(t, 6'b110101);
        add_lit(t + 12, 1, 0, 4'b0001, 1, 0, 0);

        set_req(1, 2'b00, 2'd2, 2'd3);
        wait_accept(1, t);
        add_lit(t + 12, 1, 1, 4'b0000, 0, 1, 0);

        set_req(0, 2'b11, 2'd3, 2'd3);
        set_req(1, 2'b01, 2'd1, 2'd2);
        wait_accept(0, ta);
        add_lit(ta + 12, 1, 0, 4'b1001, 0, 0, 0);
        wait_accept(1, tb);
        add_lit(ta + 18, 1, 1, 4'b1111, 0, 0, 0);

        add_din(tb + 6, 6'b100000);
        add_din(tb + 12, 6'b100000);
        add_din(tb + 30, 6'b100000);
        repeat (30) @(posedge clk);
        #1;

        set_req(0, 2'b11, 2'd3, 2'd3);
        wait_accept(0, t);
        add_lit(t + 12, 0, 0, 4'b0000, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(0, 2'b10, 2'd3, 2'd2);
        wait_accept(0, t);
        add_din(t, 6'b101110);
        add_lit(t + 12, 1, 0, 4'b0101, 0, 0, 0);

        inject = 1'b1;
        set_req(1, 2'b11, 2'd1, 2'd2);
        wait_accept(1, t);
        inject = 1'b0;
        add_lit(t + 12, 1, 1, 4'b0010, 1, 1, CHK);
        set_req(0, 2'b10, 2'd0, 2'd0);
        wait_accept(0, t);
        add_lit(t + 12, 1, 0, 4'b0000, 0, 1, 0);

        repeat (16) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
